// File: rtl/scb_pkg.sv
// Shared types and helpers for the multi-pipe scoreboard: the tracking-cell
// record, the empty micro-op code and the per-pipe latency lookup.
package scb_pkg;

   localparam int W_RD_C   = 5;
   localparam int W_UOP_C  = 6;
   localparam int W_LAT_C  = 3;
   localparam int W_AGE_C  = 4;
   localparam int W_PIPE_C = 1;

   // Micro-op code that marks an empty issue slot.
   localparam logic [W_UOP_C-1:0] unused_op = {W_UOP_C{1'b1}};

   // Pipe index reported on the write-back port when nothing is offered.
   localparam logic [W_PIPE_C-1:0] V_unpip = {W_PIPE_C{1'b0}};

   typedef struct packed {
      logic                valid;
      logic [W_PIPE_C-1:0] pipe;
      logic [W_RD_C-1:0]   rd;
      logic [W_LAT_C-1:0]  count;
      logic [W_AGE_C-1:0]  age;
   } cell_t;

   // Pull one pipe's latency out of the packed latency vector.
   function automatic logic [W_LAT_C-1:0] lat_of(input logic [31:0] p_lat, input int pipe);
      return p_lat[pipe*W_LAT_C +: W_LAT_C];
   endfunction

endpackage

// File: rtl/scb_cell.sv
// One scoreboard tracking cell: holds an in-flight micro-op, counts it down
// to completion and ages it so the oldest finished result drains first.
module scb_cell
   import scb_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clr_i,
   input  logic                ins_i,
   input  logic [W_PIPE_C-1:0] ins_pipe_i,
   input  logic [W_RD_C-1:0]   ins_rd_i,
   input  logic [W_LAT_C-1:0]  ins_count_i,
   input  logic                free_i,
   output logic                valid_o,
   output logic [W_PIPE_C-1:0] pipe_o,
   output logic [W_RD_C-1:0]   rd_o,
   output logic [W_AGE_C-1:0]  age_o,
   output logic                ready_o
);

   cell_t cell_q;
   cell_t cell_d;

   // Next cell state: flush and write-back win over insert; a live cell
   // counts down to zero and ages with saturation while it waits.
   always_comb begin
      cell_d = cell_q;
      if (clr_i) begin
         cell_d = '0;
      end else if (free_i) begin
         cell_d = '0;
      end else if (ins_i && !cell_q.valid) begin
         cell_d.valid = 1'b1;
         cell_d.pipe  = ins_pipe_i;
         cell_d.rd    = ins_rd_i;
         cell_d.count = ins_count_i;
         cell_d.age   = '0;
      end else if (cell_q.valid) begin
         if (cell_q.count != '0) begin
            cell_d.count = cell_q.count - 1'b1;
         end else begin
            cell_d.count = cell_q.count;
         end
         if (cell_q.age != '1) begin
            cell_d.age = cell_q.age + 1'b1;
         end else begin
            cell_d.age = cell_q.age;
         end
      end else begin
         cell_d = cell_q;
      end
   end

   // Cell register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cell_q <= '0;
      end else begin
         cell_q <= cell_d;
      end
   end

   assign valid_o = cell_q.valid;
   assign pipe_o  = cell_q.pipe;
   assign rd_o    = cell_q.rd;
   assign age_o   = cell_q.age;
   assign ready_o = cell_q.valid && (cell_q.count == '0);

endmodule

// File: rtl/scb_multi.sv
// Multi-pipe scoreboard top: picks at most one issuing pipe per cycle, drops
// it into the lowest free cell, tracks destination-busy registers and offers
// finished results to write-back oldest first.
module scb_multi #(
   parameter int                           W_PA_REG   = 5,
   parameter int                           W_PD_UOPS  = 6,
   parameter logic [W_PD_UOPS-1:0]         unused_op  = {W_PD_UOPS{1'b1}},
   parameter int                           S_amt_pip  = 2,
   parameter int                           S_amt_cell = 8,
   parameter int                           W_lat      = 3,
   parameter logic [S_amt_pip*W_lat-1:0]   P_lat      = {3'd4, 3'd1},
   parameter int                           W_age      = 4,
   parameter int                           W_sel      = (S_amt_pip > 1) ? $clog2(S_amt_pip) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [S_amt_pip*W_PD_UOPS-1:0]  CDI_PD_uops,
   input  logic [S_amt_pip*W_PA_REG-1:0]   CDI_PD_rd,
   input  logic [W_sel-1:0]                CDI_PC_odr,
   output logic [S_amt_pip-1:0]            CDO_PC_accept,
   output logic                            CDO_PC_full,
   output logic [(2**W_PA_REG)-1:0]        CDO_PC_busy,
   output logic                            CDO_PC_wbvalid,
   output logic [W_PA_REG-1:0]             CDO_PC_rd,
   output logic [W_sel-1:0]                CDO_PC_selwb,
   input  logic                            CDI_PC_wbready,
   input  logic                            CFI_PC_clear
);

   import scb_pkg::*;

   localparam int W_cidx = $clog2(S_amt_cell);

   logic [S_amt_cell-1:0]    valid_s;
   logic [S_amt_cell-1:0]    ready_s;
   logic [W_sel-1:0]         pipe_s   [S_amt_cell];
   logic [W_PA_REG-1:0]      crd_s    [S_amt_cell];
   logic [W_age-1:0]         age_s    [S_amt_cell];
   logic [W_age+W_cidx:0]    key_s    [S_amt_cell];
   logic [S_amt_cell-1:0]    ins_s;
   logic [S_amt_cell-1:0]    free_s;

   logic [W_PD_UOPS-1:0]     uop_s    [S_amt_pip];
   logic [W_PA_REG-1:0]      prd_s    [S_amt_pip];
   logic [S_amt_pip-1:0]     elig_s;
   logic [W_sel-1:0]         sel_s;
   logic                     any_s;
   logic [W_lat-1:0]         ins_count_s;

   logic                     full_s;
   logic [(2**W_PA_REG)-1:0] busy_s;
   logic [W_cidx-1:0]        free_idx_s;
   logic [W_age+W_cidx:0]    best_key_s;
   logic [W_cidx-1:0]        best_idx_s;
   logic                     offer_s;

   assign full_s      = &valid_s;
   assign ins_count_s = lat_of(32'(P_lat), int'(sel_s)) - 1'b1;
   assign offer_s     = best_key_s[W_age+W_cidx] && !CFI_PC_clear;

   for (genvar p = 0; p < S_amt_pip; p++) begin : g_pipe
      assign uop_s[p]  = CDI_PD_uops[p*W_PD_UOPS +: W_PD_UOPS];
      assign prd_s[p]  = CDI_PD_rd[p*W_PA_REG +: W_PA_REG];
      assign elig_s[p] = (uop_s[p] != unused_op) && !busy_s[prd_s[p]]
                         && !full_s && !CFI_PC_clear;
   end

   for (genvar g = 0; g < S_amt_cell; g++) begin : g_cell
      assign ins_s[g]  = any_s && (free_idx_s == W_cidx'(g));
      assign free_s[g] = offer_s && CDI_PC_wbready && (best_idx_s == W_cidx'(g));
      // Ready dominates, then age; inverted index makes lower cells win ties.
      assign key_s[g]  = {ready_s[g], age_s[g], ~W_cidx'(g)};

      scb_cell u_cell (
         .clk_i       (clk),
         .rst_i       (rst),
         .clr_i       (CFI_PC_clear),
         .ins_i       (ins_s[g]),
         .ins_pipe_i  (sel_s),
         .ins_rd_i    (prd_s[sel_s]),
         .ins_count_i (ins_count_s),
         .free_i      (free_s[g]),
         .valid_o     (valid_s[g]),
         .pipe_o      (pipe_s[g]),
         .rd_o        (crd_s[g]),
         .age_o       (age_s[g]),
         .ready_o     (ready_s[g])
      );
   end

   // Destination-busy vector from registered cell contents only.
   always_comb begin
      busy_s = '0;
      for (int c = 0; c < S_amt_cell; c++) begin
         if (valid_s[c]) begin
            busy_s[crd_s[c]] = 1'b1;
         end else begin
            busy_s = busy_s;
         end
      end
   end

   // Lowest-index free cell; only meaningful while not full.
   always_comb begin
      free_idx_s = '0;
      for (int c = S_amt_cell - 1; c >= 0; c--) begin
         if (!valid_s[c]) begin
            free_idx_s = W_cidx'(c);
         end else begin
            free_idx_s = free_idx_s;
         end
      end
   end

   // Issue pick: preferred pipe if it may issue, else the lowest eligible one.
   always_comb begin
      sel_s = '0;
      any_s = 1'b0;
      for (int p = S_amt_pip - 1; p >= 0; p--) begin
         if (elig_s[p]) begin
            sel_s = W_sel'(p);
            any_s = 1'b1;
         end else begin
            sel_s = sel_s;
            any_s = any_s;
         end
      end
      if ((int'(CDI_PC_odr) < S_amt_pip) && elig_s[CDI_PC_odr]) begin
         sel_s = CDI_PC_odr;
      end else begin
         sel_s = sel_s;
      end
   end

   // One-hot accept for the picked pipe.
   always_comb begin
      CDO_PC_accept = '0;
      if (any_s) begin
         CDO_PC_accept[sel_s] = 1'b1;
      end else begin
         CDO_PC_accept = '0;
      end
   end

   // Oldest-ready arbitration as a max-finder over the cell keys.
   always_comb begin
      best_key_s = key_s[0];
      best_idx_s = '0;
      for (int c = 1; c < S_amt_cell; c++) begin
         if (key_s[c] > best_key_s) begin
            best_key_s = key_s[c];
            best_idx_s = W_cidx'(c);
         end else begin
            best_key_s = best_key_s;
            best_idx_s = best_idx_s;
         end
      end
   end

   // Write-back offer; destination and pipe read as zero when idle.
   always_comb begin
      CDO_PC_wbvalid = offer_s;
      CDO_PC_full    = full_s;
      CDO_PC_busy    = busy_s;
      if (offer_s) begin
         CDO_PC_rd    = crd_s[best_idx_s];
         CDO_PC_selwb = pipe_s[best_idx_s];
      end else begin
         CDO_PC_rd    = '0;
         CDO_PC_selwb = V_unpip;
      end
   end

endmodule

// File: tb/tb_scb_multi.sv
// Bench for scb_multi: directed scenarios followed by random traffic, every
// cycle compared against a slot/issue-time model of the scoreboard.
module tb_scb_multi;

   localparam int NP = 2;
   localparam int NC = 8;
   localparam logic [5:0] NOP = 6'h3F;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] uops;
   logic [9:0]  rdv;
   logic        odr;
   logic [1:0]  accept;
   logic        full;
   logic [31:0] busy;
   logic        wbvalid;
   logic [4:0]  o_rd;
   logic        selwb;
   logic        wbready;
   logic        clear;

   always #5 clk = ~clk;

   scb_multi dut (
      .clk            (clk),
      .rst            (rst),
      .CDI_PD_uops    (uops),
      .CDI_PD_rd      (rdv),
      .CDI_PC_odr     (odr),
      .CDO_PC_accept  (accept),
      .CDO_PC_full    (full),
      .CDO_PC_busy    (busy),
      .CDO_PC_wbvalid (wbvalid),
      .CDO_PC_rd      (o_rd),
      .CDO_PC_selwb   (selwb),
      .CDI_PC_wbready (wbready),
      .CFI_PC_clear   (clear)
   );

   int total = 0;
   int bad   = 0;

   // Model: which slot holds what, and the edge number at which it was issued.
   bit m_v    [NC];
   int m_pipe [NC];
   int m_rd   [NC];
   int m_e    [NC];
   int lat    [NP];
   int now;

   logic [1:0]  e_acc;
   logic        e_full;
   logic [31:0] e_busy;
   logic        e_wbv;
   logic [4:0]  e_rd;
   logic        e_sel;
   int          e_off;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_eval();
      int best;
      int best_age;
      int age;
      int sel;
      logic [1:0] el;
      e_busy = '0;
      e_full = 1'b1;
      for (int c = 0; c < NC; c++) begin
         if (m_v[c]) e_busy[m_rd[c]] = 1'b1;
         else e_full = 1'b0;
      end
      for (int p = 0; p < NP; p++)
         el[p] = (uops[p*6 +: 6] != NOP) && !e_busy[rdv[p*5 +: 5]] && !e_full && !clear;
      sel = -1;
      if (el[odr]) sel = int'(odr);
      else for (int p = NP - 1; p >= 0; p--) if (el[p]) sel = p;
      e_acc = 2'b00;
      if (sel >= 0) e_acc[sel] = 1'b1;
      best = -1;
      best_age = -1;
      for (int c = 0; c < NC; c++) begin
         if (m_v[c] && (now - m_e[c]) >= lat[m_pipe[c]] - 1) begin
            age = now - m_e[c];
            if (age > 15) age = 15;
            if (age > best_age) begin
               best = c;
               best_age = age;
            end
         end
      end
      e_off = best;
      e_wbv = (best >= 0) && !clear;
      e_rd  = 5'd0;
      e_sel = 1'b0;
      if (e_wbv) begin
         e_rd  = 5'(m_rd[best]);
         e_sel = (m_pipe[best] == 1);
      end
   endtask

   task automatic model_commit();
      int slot;
      int p;
      if (rst || clear) begin
         for (int c = 0; c < NC; c++) m_v[c] = 1'b0;
      end else begin
         slot = -1;
         for (int c = NC - 1; c >= 0; c--) if (!m_v[c]) slot = c;
         if (e_wbv && wbready) m_v[e_off] = 1'b0;
         if (e_acc != 2'b00 && slot >= 0) begin
            p = e_acc[1] ? 1 : 0;
            m_v[slot]    = 1'b1;
            m_pipe[slot] = p;
            m_rd[slot]   = int'(rdv[p*5 +: 5]);
            m_e[slot]    = now + 1;
         end
      end
      now++;
   endtask

   task automatic drive(input logic [5:0] u0, input logic [4:0] r0,
                        input logic [5:0] u1, input logic [4:0] r1,
                        input logic o, input logic wr, input logic cl);
      uops    = {u1, u0};
      rdv     = {r1, r0};
      odr     = o;
      wbready = wr;
      clear   = cl;
      #1;
      model_eval();
      chk("accept",  32'(accept),  32'(e_acc));
      chk("full",    32'(full),    32'(e_full));
      chk("busy",    busy,         e_busy);
      chk("wbvalid", 32'(wbvalid), 32'(e_wbv));
      chk("wb_rd",   32'(o_rd),    32'(e_rd));
      chk("selwb",   32'(selwb),   32'(e_sel));
   endtask

   task automatic idle(input logic wr);
      drive(NOP, 5'd0, NOP, 5'd0, 1'b0, wr, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic drain();
      bit any;
      for (int i = 0; i < 40; i++) begin
         any = 1'b0;
         for (int c = 0; c < NC; c++) if (m_v[c]) any = 1'b1;
         if (!any) break;
         idle(1'b1);
         tick();
      end
      idle(1'b0);
      chk("drain_busy", busy, 32'd0);
      tick();
   endtask

   initial begin
      lat[0] = 1;
      lat[1] = 4;
      now = 0;
      for (int c = 0; c < NC; c++) m_v[c] = 1'b0;
      rst = 1'b1;
      uops = {NOP, NOP};
      rdv = 10'd0;
      odr = 1'b0;
      wbready = 1'b0;
      clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      idle(1'b0);
      chk("rst_accept", 32'(accept), 32'd0);
      chk("rst_full",   32'(full),   32'd0);
      chk("rst_busy",   busy,        32'd0);
      chk("rst_wbv",    32'(wbvalid), 32'd0);
      chk("rst_rd",     32'(o_rd),   32'd0);
      chk("rst_selwb",  32'(selwb),  32'd0);
      tick();

      // Single L=1 op on pipe 0
      drive(6'd1, 5'd5, NOP, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("t1_acc", 32'(accept), 32'd1);
      tick();
      idle(1'b1);
      chk("t1_busy5", 32'(busy[5]), 32'd1);
      chk("t1_wbv",   32'(wbvalid), 32'd1);
      chk("t1_rd",    32'(o_rd),    32'd5);
      chk("t1_sel",   32'(selwb),   32'd0);
      tick();
      idle(1'b0);
      chk("t1_busy5_clr", 32'(busy[5]), 32'd0);
      tick();

      // Preferred pipe 1 (L=4)
      drive(6'd2, 5'd3, 6'd3, 5'd4, 1'b1, 1'b0, 1'b0);
      chk("t2_acc", 32'(accept), 32'd2);
      tick();
      for (int i = 0; i < 3; i++) begin
         idle(1'b0);
         chk("t2_wait", 32'(wbvalid), 32'd0);
         tick();
      end
      idle(1'b1);
      chk("t2_wbv", 32'(wbvalid), 32'd1);
      chk("t2_rd",  32'(o_rd),    32'd4);
      chk("t2_sel", 32'(selwb),   32'd1);
      tick();

      // WAW block on rd 7
      drive(6'd4, 5'd7, NOP, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(NOP, 5'd0, 6'd5, 5'd7, 1'b1, 1'b0, 1'b0);
      chk("t3_block", 32'(accept), 32'd0);
      tick();
      drive(NOP, 5'd0, 6'd5, 5'd7, 1'b1, 1'b1, 1'b0);
      chk("t3_wbcyc", 32'(accept), 32'd0);
      tick();
      drive(NOP, 5'd0, 6'd5, 5'd7, 1'b1, 1'b0, 1'b0);
      chk("t3_after", 32'(accept), 32'd2);
      tick();
      drain();

      // Fill all cells
      for (int i = 0; i < 8; i++) begin
         drive(6'd6, 5'(8 + i), NOP, 5'd0, 1'b0, 1'b0, 1'b0);
         chk("t4_fill", 32'(accept), 32'd1);
         tick();
      end
      drive(6'd6, 5'd16, NOP, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("t4_full",  32'(full),   32'd1);
      chk("t4_rej",   32'(accept), 32'd0);
      tick();
      drive(6'd6, 5'd16, NOP, 5'd0, 1'b0, 1'b1, 1'b0);
      chk("t4_full_wb", 32'(full),   32'd1);
      chk("t4_rej_wb",  32'(accept), 32'd0);
      tick();
      drive(6'd6, 5'd16, NOP, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("t4_notfull", 32'(full),   32'd0);
      chk("t4_ninth",   32'(accept), 32'd1);
      tick();
      drain();

      // Oldest-first between pipes
      drive(NOP, 5'd0, 6'd7, 5'd20, 1'b0, 1'b0, 1'b0);
      tick();
      idle(1'b0);
      tick();
      idle(1'b0);
      tick();
      drive(6'd8, 5'd21, NOP, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
      idle(1'b0);
      chk("t5_old_rd",  32'(o_rd),  32'd20);
      chk("t5_old_sel", 32'(selwb), 32'd1);
      tick();
      idle(1'b1);
      chk("t5_hold_rd", 32'(o_rd), 32'd20);
      tick();
      idle(1'b0);
      chk("t5_new_rd",  32'(o_rd),  32'd21);
      chk("t5_new_sel", 32'(selwb), 32'd0);
      tick();
      drain();

      // Clear with 5 pending cells
      for (int i = 0; i < 5; i++) begin
         drive(NOP, 5'd0, 6'd9, 5'(1 + i), 1'b1, 1'b0, 1'b0);
         tick();
      end
      drive(6'd10, 5'd9, NOP, 5'd0, 1'b0, 1'b1, 1'b1);
      chk("t6_wbv", 32'(wbvalid), 32'd0);
      chk("t6_acc", 32'(accept),  32'd0);
      tick();
      idle(1'b0);
      chk("t6_busy", busy,       32'd0);
      chk("t6_full", 32'(full),  32'd0);
      tick();

      // Reset mid-operation
      drive(6'd11, 5'd12, NOP, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(NOP, 5'd0, 6'd12, 5'd13, 1'b1, 1'b0, 1'b0);
      tick();
      rst = 1'b1;
      idle(1'b1);
      tick();
      rst = 1'b0;
      idle(1'b0);
      chk("t7_busy", busy,          32'd0);
      chk("t7_wbv",  32'(wbvalid),  32'd0);
      tick();

      // Random traffic: slow then fast write-back
      for (int ph = 0; ph < 2; ph++) begin
         for (int i = 0; i < 300; i++) begin
            logic [5:0] u0;
            logic [5:0] u1;
            u0 = ($urandom_range(0, 3) == 0) ? NOP : 6'($urandom_range(0, 62));
            u1 = ($urandom_range(0, 3) == 0) ? NOP : 6'($urandom_range(0, 62));
            drive(u0, 5'($urandom_range(0, 11)), u1, 5'($urandom_range(0, 11)),
                  1'($urandom_range(0, 1)),
                  (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 39) == 0));
            tick();
         end
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/scb_multi.md
# scb_multi

Parametrised scoreboard for N execution pipes with configurable per-pipe latency, write-back back-pressure, WAW protection and a destination-busy vector. It sits between the reservation station and the reorder buffer write-back stage. Each cycle it accepts at most one micro-op into a free tracking cell and counts the cell down to its pipe's completion. It then releases completed results to write-back oldest-first.

## Interface
Parameters:
- W_PA_REG, 5, register address width
- W_PD_UOPS, 6, micro-op width
- unused_op, {W_PD_UOPS{1'b1}}, micro-op code meaning "no op"
- S_amt_pip, 2, number of execution pipes (≥1)
- S_amt_cell, 8, number of tracking cells (power of 2, ≥2)
- W_lat, 3, latency field width
- P_lat, {3'd4,3'd1}, packed per-pipe latency; pipe i at [i*W_lat +: W_lat]; each value in 1..2^W_lat-1
- W_age, 4, saturating age counter width
- W_sel, $clog2(S_amt_pip) (min 1), pipe index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- CDI_PD_uops  in  S_amt_pip*W_PD_UOPS  per-pipe micro-op; unused_op = empty
- CDI_PD_rd  in  S_amt_pip*W_PA_REG  per-pipe destination
- CDI_PC_odr  in  W_sel  preferred pipe when several are eligible
- CDO_PC_accept  out  S_amt_pip  one-hot accept (all 0 = none)
- CDO_PC_full  out  1  no free cell
- CDO_PC_busy  out  2^W_PA_REG  bit r = register r has a pending write
- CDO_PC_wbvalid  out  1  a completed result is offered
- CDO_PC_rd  out  W_PA_REG  destination of the offered result (0 when not valid)
- CDO_PC_selwb  out  W_sel  pipe of the offered result (0 when not valid)
- CDI_PC_wbready  in  1  write-back consumes the offer this edge
- CFI_PC_clear  in  1  flush all cells

## Operation
- Cell state: valid, pipe, rd, count[W_lat], age[W_age].
- Eligible pipe: uops != unused_op, busy[rd]==0 (WAW block), !full, !clear.
- Two eligible pipes with the same rd: only the selected one is accepted.
- Selection: CDI_PC_odr if eligible, else the lowest-index eligible pipe.
- Insert at the edge into the lowest-index free cell: valid=1, count=P_lat[pipe]-1, age=0.
- Valid cells with count>0 decrement each edge.
- Every valid cell's age increments each edge, saturating at 2^W_age-1.
- Ready cell: valid && count==0.
- Offer: among ready cells, maximum age; ties go to the lowest index.
- Ready cells not chosen hold count=0 and keep ageing (structural stall).
- wbvalid && wbready at an edge frees the offered cell.
- busy[r] = OR over valid cells with rd==r. It is computed from registered state only.
- Clear or rst: all cells invalid at the edge; age reset to 0.
- While clear is high: accept=0 and wbvalid=0. The offer is not consumed even if wbready=1.

## Timing
- Reset values: accept=0, full=0, busy=0, wbvalid=0, CDO_PC_rd=0, CDO_PC_selwb=0.
- accept, full, busy and offer outputs are combinational, driven from registered cell state and current inputs; no input→output loop through wbready.
- A cell freed at edge t is insertable from cycle t+1, not in the same cycle.
- Busy for a written-back rd clears in cycle t+1. An issue to that rd in the write-back cycle is rejected and succeeds in t+1.
- Accept at edge t on a pipe of latency L: wbvalid first high in cycle t+L-1 after that edge; L=1 gives wbvalid in the next cycle.
- A stalled offer (wbready=0) holds rd and selwb stable until consumed, unless an older ready cell appears; age ordering prevents this for cells already waiting.
- Full: all S_amt_cell valid. Simultaneous write-back does not relieve full in the same cycle.
- rst mid-operation discards all pending results with no write-back.

## Structure
- Package scb_pkg holds:
  - the cell struct (valid, pipe, rd, count, age)
  - unused_op
  - the V_unpip constant
  - a latency-extract function
- Sub-module scb_cell holds one cell's registers, decrement and age logic, and its ready flag.
- The top level holds issue selection, free-cell priority encoding, oldest-ready arbitration (a max-finder over {ready, age, ~index}) and the busy OR-reduction.

## Test plan
- Single op, pipe 0 (L=1), rd=5 → accept=01, busy[5]=1, wbvalid next cycle with rd=5, selwb=0; busy[5]=0 one cycle after wbready.
- Both pipes valid, rd 3/4, odr=1 → accept=10; pipe 1 (L=4) offers rd=4 three cycles after the accept edge.
- Issue rd=7 while rd=7 pending → accept=00 until the cycle after write-back, then accepted.
- Eight issues with wbready=0 → full=1, ninth rejected; one wbready pulse → full=0 the next cycle, ninth accepted.
- Pipe 1 op issued cycle 0 and pipe 0 op issued cycle 3 both ready in cycle 4, wbready=0 → offer is the pipe-1 op (older) first, then the pipe-0 op.
- Clear asserted with 5 pending cells and wbready=1 → wbvalid=0 that cycle, busy=0 and full=0 next cycle, no write-back emitted.
